// File: rtl/energy_pkg.sv
// Shared widths, pipeline latency and FSM state type for the energy frame controller.
package energy_pkg;

    localparam int SAMPLE_W = 16;
    localparam int SQUARE_W = 31;
    localparam int ENERGY_W = 39;
    localparam int PIPE_LAT = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/energy_frame_ctrl_if.sv
// Scheduler, sample RAM, energy datapath and consumer signals of energy_frame_ctrl.
// ENERGY_THRESH_EN adds the threshold input and above_thresh flag.
interface energy_frame_ctrl_if #(
    parameter int ADDR_W = 8,
    parameter int LEN_W  = 9
) ();
    import energy_pkg::*;

    logic                start;
    logic [ADDR_W-1:0]   base_addr;
    logic [LEN_W-1:0]    frame_len;
    logic                busy;
    logic [ADDR_W-1:0]   ram_addr;
    logic                ram_rd;
    logic                square_en;
    logic                eadder_en;
    logic                eadder_new;
    logic                eadder_sel;
    logic [ENERGY_W-1:0] eadder_out;
    logic [ENERGY_W-1:0] ereg_out;
    logic [ENERGY_W-1:0] energy_out;
    logic                energy_valid;
`ifdef ENERGY_THRESH_EN
    logic [ENERGY_W-1:0] thresh;
    logic                above_thresh;
`endif

    modport slave (
`ifdef ENERGY_THRESH_EN
        input  thresh,
        output above_thresh,
`endif
        input  start, base_addr, frame_len, eadder_out,
        output busy, ram_addr, ram_rd, square_en, eadder_en, eadder_new,
        output eadder_sel, ereg_out, energy_out, energy_valid
    );

    modport master (
`ifdef ENERGY_THRESH_EN
        output thresh,
        input  above_thresh,
`endif
        output start, base_addr, frame_len, eadder_out,
        input  busy, ram_addr, ram_rd, square_en, eadder_en, eadder_new,
        input  eadder_sel, ereg_out, energy_out, energy_valid
    );

endinterface

// File: rtl/energy_frame_ctrl_addr_gen.sv
// Read address generator: circular-buffer address, remaining-read down-counter,
// two-cycle issue phase and last-read flag.
module energy_addr_gen #(
    parameter int ADDR_W = 8,
    parameter int LEN_W  = 9
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_i,
    input  logic              run_i,
    input  logic [ADDR_W-1:0] base_i,
    input  logic [LEN_W-1:0]  len_i,
    output logic              issue_o,
    output logic [ADDR_W-1:0] addr_o,
    output logic              last_o
);

    logic [ADDR_W-1:0] next_addr_q, next_addr_d;
    logic [LEN_W-1:0]  remain_q, remain_d;
    logic              phase_q, phase_d;

    // Read 0 issues on the load edge itself, so the counter holds the reads still owed.
    assign last_o  = (remain_q == '0);
    assign issue_o = load_i | (run_i & phase_q & ~last_o);
    assign addr_o  = load_i ? base_i : next_addr_q;

    always_comb begin
        next_addr_d = next_addr_q;
        remain_d    = remain_q;
        phase_d     = phase_q;
        if (load_i) begin
            remain_d = len_i - LEN_W'(1);
            phase_d  = 1'b0;
        end else if (run_i) begin
            phase_d = ~phase_q;
            if (issue_o) begin
                remain_d = remain_q - LEN_W'(1);
            end
        end
        if (issue_o) begin
            next_addr_d = addr_o + ADDR_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            next_addr_q <= '0;
            remain_q    <= '0;
            phase_q     <= 1'b0;
        end else begin
            next_addr_q <= next_addr_d;
            remain_q    <= remain_d;
            phase_q     <= phase_d;
        end
    end

endmodule

// File: rtl/energy_frame_ctrl.sv
// Frame sequencer and energy register stage for the square + eadder datapath.
// Optional ENERGY_THRESH_EN adds a registered above-threshold flag.
//
// state | meaning
// IDLE  | waiting for start; holds last energy result
// RUN   | issuing one sample read every two cycles
// DRAIN | all reads issued; waiting for the last ereg load
// DONE  | one cycle: energy_valid pulse, then back to IDLE
module energy_frame_ctrl
    import energy_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int LEN_W  = 9
) (
    input  logic              clk,
    input  logic              rst,
    energy_frame_ctrl_if.slave bus
);

    state_t              state_q;
    logic                busy_q;
    logic [ADDR_W-1:0]   ram_addr_q;
    logic [PIPE_LAT:0]   vld_q;
    logic [PIPE_LAT-1:0] first_q;
    logic [ENERGY_W-1:0] ereg_q;
    logic [ENERGY_W-1:0] energy_q;
    logic                evalid_q;

    logic                accept_read;
    logic                issue;
    logic                last_read;
    logic [ADDR_W-1:0]   rd_addr;
    logic                last_load;

    assign accept_read = (state_q == IDLE) && bus.start && (bus.frame_len != '0);
    // The final ereg load is the only valid bit left once all reads are issued.
    assign last_load   = vld_q[PIPE_LAT] && (vld_q[PIPE_LAT-1:0] == '0);

    energy_addr_gen #(
        .ADDR_W (ADDR_W),
        .LEN_W  (LEN_W)
    ) u_addr_gen (
        .clk     (clk),
        .rst     (rst),
        .load_i  (accept_read),
        .run_i   (state_q == RUN),
        .base_i  (bus.base_addr),
        .len_i   (bus.frame_len),
        .issue_o (issue),
        .addr_o  (rd_addr),
        .last_o  (last_read)
    );

`ifdef ENERGY_THRESH_EN
    logic above_q;
    assign bus.above_thresh = above_q;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            busy_q     <= 1'b0;
            ram_addr_q <= '0;
            vld_q      <= '0;
            first_q    <= '0;
            ereg_q     <= '0;
            energy_q   <= '0;
            evalid_q   <= 1'b0;
`ifdef ENERGY_THRESH_EN
            above_q    <= 1'b0;
`endif
        end else begin
            vld_q    <= {vld_q[PIPE_LAT-1:0], issue};
            first_q  <= {first_q[PIPE_LAT-2:0], accept_read};
            evalid_q <= 1'b0;
            if (issue) begin
                ram_addr_q <= rd_addr;
            end
            if (vld_q[PIPE_LAT]) begin
                ereg_q <= bus.eadder_out;
            end
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        busy_q <= 1'b1;
                        if (bus.frame_len == '0) begin
                            state_q  <= DONE;
                            evalid_q <= 1'b1;
                            energy_q <= '0;
`ifdef ENERGY_THRESH_EN
                            above_q  <= (ereg_q > bus.thresh);
`endif
                        end else begin
                            state_q <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (last_read) begin
                        state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (last_load) begin
                        state_q  <= DONE;
                        evalid_q <= 1'b1;
                        energy_q <= bus.eadder_out;
`ifdef ENERGY_THRESH_EN
                        above_q  <= (bus.eadder_out > bus.thresh);
`endif
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.busy         = busy_q;
    assign bus.ram_addr     = ram_addr_q;
    assign bus.ram_rd       = vld_q[0];
    assign bus.square_en    = vld_q[1];
    assign bus.eadder_en    = vld_q[2];
    assign bus.eadder_new   = first_q[PIPE_LAT-1];
    assign bus.eadder_sel   = 1'b0;
    assign bus.ereg_out     = ereg_q;
    assign bus.energy_out   = energy_q;
    assign bus.energy_valid = evalid_q;

endmodule

// File: tb/tb_energy_frame_ctrl.sv
// Directed bench for energy_frame_ctrl with a behavioural sample RAM, square and eadder.
module tb_energy_frame_ctrl;
    import energy_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    energy_frame_ctrl_if bus_if ();
    energy_frame_ctrl dut (.clk(clk), .rst(rst), .bus(bus_if));

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Datapath model: RAM data next cycle, square registered, eadder registered.
    logic [SAMPLE_W-1:0] mem [256];
    logic [SAMPLE_W-1:0] rd_data;
    logic signed [31:0]  samp_ext;
    logic signed [31:0]  prod;
    logic [31:0]         sq;
    assign samp_ext = {{16{rd_data[15]}}, rd_data};
    assign prod     = samp_ext * samp_ext;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data           <= '0;
            sq                <= '0;
            bus_if.eadder_out <= '0;
        end else begin
            if (bus_if.ram_rd)    rd_data <= mem[bus_if.ram_addr];
            if (bus_if.square_en) sq <= prod;
            if (bus_if.eadder_en)
                bus_if.eadder_out <= (bus_if.eadder_new ? 39'd0 : bus_if.ereg_out) + {7'd0, sq};
        end
    end

    int                  rd_cnt, sq_cnt, ea_cnt, new_cnt, new_cyc, vld_cyc;
    int                  rd_cyc [4];
    logic [7:0]          rd_adr [4];
    logic [ENERGY_W-1:0] e_out;
    logic                ab_out;

    task automatic run_frame(input logic [7:0] base, input logic [8:0] len, input bit poke);
        rd_cnt = 0; sq_cnt = 0; ea_cnt = 0; new_cnt = 0; new_cyc = -1; vld_cyc = -1;
        ab_out = 1'b0;
        @(negedge clk);
        bus_if.start     = 1'b1;
        bus_if.base_addr = base;
        bus_if.frame_len = len;
        @(posedge clk);
        #1 bus_if.start = 1'b0;
        for (int c = 1; c <= 600 && vld_cyc < 0; c++) begin
            @(negedge clk);
            if (bus_if.ram_rd) begin
                if (rd_cnt < 4) begin
                    rd_cyc[rd_cnt] = c;
                    rd_adr[rd_cnt] = bus_if.ram_addr;
                end
                rd_cnt++;
            end
            if (bus_if.square_en) sq_cnt++;
            if (bus_if.eadder_en) ea_cnt++;
            if (bus_if.eadder_new) begin
                new_cnt++;
                new_cyc = c;
            end
            if (bus_if.energy_valid) begin
                vld_cyc = c;
                e_out   = bus_if.energy_out;
`ifdef ENERGY_THRESH_EN
                ab_out  = bus_if.above_thresh;
`endif
            end
            if (poke) begin
                bus_if.start     = (c >= 2 && c <= 5);
                bus_if.base_addr = 8'h55;
                bus_if.frame_len = 9'd3;
            end
        end
        bus_if.start = 1'b0;
        if (vld_cyc < 0) chk("valid_timeout", 64'd0, 64'd1);
    endtask

    int busy_seen;
    int vld_seen;

    initial begin
        bus_if.start     = 1'b0;
        bus_if.base_addr = '0;
        bus_if.frame_len = '0;
`ifdef ENERGY_THRESH_EN
        bus_if.thresh    = '0;
`endif
        for (int i = 0; i < 256; i++) mem[i] = '0;

        #2 rst = 1'b1;
        #1;
        chk("rst_busy",   bus_if.busy, 0);
        chk("rst_ram_rd", bus_if.ram_rd, 0);
        chk("rst_valid",  bus_if.energy_valid, 0);
        chk("rst_energy", bus_if.energy_out, 0);
        chk("rst_ereg",   bus_if.ereg_out, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // base 0x10, samples 1..4 -> 30
        mem[8'h10] = 16'd1; mem[8'h11] = 16'd2; mem[8'h12] = 16'd3; mem[8'h13] = 16'd4;
        run_frame(8'h10, 9'd4, 1'b0);
        chk("t1_rd_cnt",  rd_cnt, 4);
        chk("t1_rd_cyc0", rd_cyc[0], 1);
        chk("t1_rd_cyc1", rd_cyc[1], 3);
        chk("t1_rd_cyc2", rd_cyc[2], 5);
        chk("t1_rd_cyc3", rd_cyc[3], 7);
        chk("t1_adr0",    rd_adr[0], 8'h10);
        chk("t1_adr3",    rd_adr[3], 8'h13);
        chk("t1_new_cnt", new_cnt, 1);
        chk("t1_new_cyc", new_cyc, 3);
        chk("t1_sq_cnt",  sq_cnt, 4);
        chk("t1_ea_cnt",  ea_cnt, 4);
        chk("t1_vld_cyc", vld_cyc, 11);
        chk("t1_energy",  e_out, 30);
        @(negedge clk);
        chk("t1_pulse",   bus_if.energy_valid, 0);
        chk("t1_busy_dn", bus_if.busy, 0);
        chk("t1_hold",    bus_if.energy_out, 30);
        chk("t1_ereg",    bus_if.ereg_out, 30);
        chk("t1_sel",     bus_if.eadder_sel, 0);

        // wrap-around: FE,FF,00,01 = 5,-6,7,8 -> 25+36+49+64 = 174
        mem[8'hFE] = 16'd5; mem[8'hFF] = 16'hFFFA; mem[8'h00] = 16'd7; mem[8'h01] = 16'd8;
        run_frame(8'hFE, 9'd4, 1'b0);
        chk("t2_adr0",    rd_adr[0], 8'hFE);
        chk("t2_adr1",    rd_adr[1], 8'hFF);
        chk("t2_adr2",    rd_adr[2], 8'h00);
        chk("t2_adr3",    rd_adr[3], 8'h01);
        chk("t2_energy",  e_out, 174);
        chk("t2_vld_cyc", vld_cyc, 11);

        // empty frame
        run_frame(8'h20, 9'd0, 1'b0);
        chk("t3_vld_cyc", vld_cyc, 1);
        chk("t3_energy",  e_out, 0);
        chk("t3_rd_cnt",  rd_cnt, 0);
        chk("t3_sq_cnt",  sq_cnt, 0);
        chk("t3_ea_cnt",  ea_cnt, 0);

        // start pulses during a busy frame are neither honoured nor queued
        run_frame(8'h10, 9'd4, 1'b1);
        chk("t4_energy",  e_out, 30);
        chk("t4_vld_cyc", vld_cyc, 11);
        chk("t4_rd_cnt",  rd_cnt, 4);
        busy_seen = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (bus_if.busy) busy_seen++;
        end
        chk("t4_no_queue", busy_seen, 0);

        // reset in cycle 4 of an N=4 frame
        @(negedge clk);
        bus_if.start = 1'b1; bus_if.base_addr = 8'h10; bus_if.frame_len = 9'd4;
        @(posedge clk);
        #1 bus_if.start = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("t5_busy",   bus_if.busy, 0);
        chk("t5_ram_rd", bus_if.ram_rd, 0);
        chk("t5_sq_en",  bus_if.square_en, 0);
        chk("t5_ea_en",  bus_if.eadder_en, 0);
        chk("t5_ereg",   bus_if.ereg_out, 0);
        chk("t5_energy", bus_if.energy_out, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        vld_seen = 0;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            if (bus_if.energy_valid) vld_seen++;
        end
        chk("t5_no_valid", vld_seen, 0);
        run_frame(8'h10, 9'd4, 1'b0);
        chk("t5_energy2", e_out, 30);
        chk("t5_new_cyc", new_cyc, 3);
        chk("t5_vld_cyc", vld_cyc, 11);

`ifdef ENERGY_THRESH_EN
        bus_if.thresh = 39'd29;
        run_frame(8'h10, 9'd4, 1'b0);
        chk("th_energy30", e_out, 30);
        chk("th_above30",  ab_out, 1);
        mem[8'h30] = 16'd2; mem[8'h31] = 16'd5; mem[8'h32] = 16'd0; mem[8'h33] = 16'd0;
        run_frame(8'h30, 9'd4, 1'b0);
        chk("th_energy29", e_out, 29);
        chk("th_above29",  ab_out, 0);
`endif

        // full-scale 256-sample frame: 256 * 2^30 = 2^38
        for (int i = 0; i < 256; i++) mem[i] = 16'h8000;
        run_frame(8'h00, 9'd256, 1'b0);
        chk("t6_energy",  e_out, 64'd274877906944);
        chk("t6_vld_cyc", vld_cyc, 515);
        chk("t6_rd_cnt",  rd_cnt, 256);
        chk("t6_new_cnt", new_cnt, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
